// File: rtl/lstm_timestep_scheduler.sv
// Multi-timestep sequencer for the LSTM core: Xi load, DMA write ctrl, core run,
// and an ht FIFO drained onto the 64-bit DMA write channel.
module lstm_timestep_scheduler #(
  parameter int HIDDEN     = 64,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int TS_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  input  logic [TS_WIDTH-1:0]   cfg_num_timesteps,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  x_load_req,
  output logic [TS_WIDTH-1:0]   x_load_ts,
  input  logic                  x_load_ack,
  output logic                  core_start,
  input  logic                  core_ht_valid,
  input  logic [DATA_WIDTH-1:0] core_ht_out,
  input  logic                  core_done,
  output logic                  wr_ctrl_valid,
  input  logic                  wr_ctrl_ready,
  output logic [31:0]           wr_ctrl_index,
  output logic [31:0]           wr_ctrl_length,
  output logic [2:0]            wr_ctrl_size,
  output logic                  wr_chnl_valid,
  input  logic                  wr_chnl_ready,
  output logic [63:0]           wr_chnl_data
);

  // state | meaning
  // IDLE  | waiting for cfg_valid
  // XREQ  | requesting Xi load for ts
  // WCTRL | issuing DMA write ctrl for ts
  // RUN   | core running, ht beats buffered
  // FLUSH | waiting for the FIFO to drain
  // NEXT  | advance ts, clear per-timestep counters
  // FIN   | one-cycle done pulse
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_XREQ  = 3'd1;
  localparam logic [2:0] S_WCTRL = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FLUSH = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(HIDDEN) + 1;
  localparam logic [31:0]   HIDDEN_W = 32'(HIDDEN);
  localparam logic [CW-1:0] HIDDEN_C = CW'(HIDDEN);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

  logic [2:0]            state_q, state_d;
  logic [TS_WIDTH-1:0]   n_q, n_d, ts_q, ts_d, ts_inc;
  logic                  err_q, err_d;
  logic [CW-1:0]         ht_cnt_q, ht_cnt_d, sent_cnt_q, sent_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  fifo_empty, fifo_full, push_req, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign pop        = !fifo_empty && wr_chnl_ready;
  assign push_req   = (state_q == S_RUN) && core_ht_valid;
  // A full FIFO still accepts a beat when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);
  assign ts_inc     = ts_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    ts_d       = ts_q;
    err_d      = err_q;
    ht_cnt_d   = ht_cnt_q;
    sent_cnt_d = sent_cnt_q;
    if (push) ht_cnt_d = ht_cnt_q + 1'b1;
    if (pop) sent_cnt_d = sent_cnt_q + 1'b1;
    if (push_req && !push) err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          n_d        = cfg_num_timesteps;
          ts_d       = '0;
          err_d      = 1'b0;
          ht_cnt_d   = '0;
          sent_cnt_d = '0;
          state_d    = (cfg_num_timesteps == '0) ? S_FIN : S_XREQ;
        end
      end
      S_XREQ:  if (x_load_ack) state_d = S_WCTRL;
      S_WCTRL: if (wr_ctrl_ready) state_d = S_RUN;
      S_RUN:   if (core_done) state_d = S_FLUSH;
      S_FLUSH: begin
        if (fifo_empty && (sent_cnt_q == ht_cnt_q)) begin
          state_d = S_NEXT;
          if (ht_cnt_q != HIDDEN_C) err_d = 1'b1;
        end
      end
      S_NEXT: begin
        ts_d       = ts_inc;
        ht_cnt_d   = '0;
        sent_cnt_d = '0;
        state_d    = (ts_inc == n_q) ? S_FIN : S_XREQ;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      ts_q       <= '0;
      err_q      <= 1'b0;
      ht_cnt_q   <= '0;
      sent_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      ts_q       <= ts_d;
      err_q      <= err_d;
      ht_cnt_q   <= ht_cnt_d;
      sent_cnt_q <= sent_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= core_ht_out;
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_FIN);
  assign err            = err_q;
  assign x_load_req     = (state_q == S_XREQ);
  assign x_load_ts      = ts_q;
  assign core_start     = (state_q == S_RUN);
  assign wr_ctrl_valid  = (state_q == S_WCTRL);
  assign wr_ctrl_index  = 32'(ts_q) * HIDDEN_W;
  assign wr_ctrl_length = HIDDEN_W;
  assign wr_ctrl_size   = 3'd3;
  assign wr_chnl_valid  = !fifo_empty;
  assign wr_chnl_data   = fifo_empty ? 64'd0 : 64'(mem_q[rd_ptr_q]);

endmodule
